lhca_sequencer: RTL and testbench

// - Command-driven controller for an N-cell hybrid 90/150 cellular automaton with null boundaries.
// - Holds the CA state register, the per-cell rule mask and a free-running prescaler.
// - Sequences the CA as load seed / run / pause / single step.
// - Measures the cycle period of the CA (steps until the state returns to the seed).
// - Sits between the board top level (LEDs, buttons, UART command decoder) and the CA datapath.

---
 rtl/lhca_pkg.sv | 18 +
 rtl/lhca_next.sv | 21 ++
 rtl/lhca_sequencer.sv | 124 ++++++++++++
 tb/tb_lhca_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/lhca_pkg.sv
// Shared encodings for the hybrid 90/150 cellular-automaton sequencer.
package lhca_pkg;

  localparam int unsigned LHCA_OP_W     = 2;
  localparam int unsigned LHCA_PERIOD_W = 16;

  localparam logic [LHCA_OP_W-1:0] LHCA_OP_LOAD     = 2'd0;
  localparam logic [LHCA_OP_W-1:0] LHCA_OP_RULE     = 2'd1;
  localparam logic [LHCA_OP_W-1:0] LHCA_OP_RUN      = 2'd2;
  localparam logic [LHCA_OP_W-1:0] LHCA_OP_STOPSTEP = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STEP = 2'd2
  } lhca_state_t;

endpackage

// File: rtl/lhca_next.sv
// Next-state function of a null-boundary hybrid 90/150 cellular automaton.
module lhca_next #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] rule,
  output logic [WIDTH-1:0] n
);

  // Zero cells on both ends model the null boundaries.
  logic [WIDTH+1:0] pad;
  assign pad = {1'b0, s, 1'b0};

  always_comb begin
    n = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      n[i] = pad[i] ^ pad[i+2] ^ (rule[i] & s[i]);
    end
  end

endmodule

// File: rtl/lhca_sequencer.sv
// Command-driven controller for a hybrid 90/150 CA: seed/rule load, run/stop/step
// sequencing with a free-running prescaler, and seed-to-seed period measurement.
module lhca_sequencer
  import lhca_pkg::*;
#(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      PRESCALE_BITS = 22,
  parameter logic [WIDTH-1:0] RULE_RESET    = WIDTH'(8'h06),
  parameter logic [WIDTH-1:0] SEED_RESET    = WIDTH'(8'h01)
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     CMD_VALID,
  output logic                     CMD_READY,
  input  logic [LHCA_OP_W-1:0]     CMD_OP,
  input  logic [WIDTH-1:0]         CMD_DATA,
  output logic [WIDTH-1:0]         O,
  output logic                     STEP_PULSE,
  output logic                     RUNNING,
  output logic [LHCA_PERIOD_W-1:0] PERIOD,
  output logic                     PERIOD_VALID
);

  localparam logic [LHCA_PERIOD_W-1:0] CNT_SAT = '1;

  lhca_state_t              state;
  lhca_state_t              state_next;
  logic [PRESCALE_BITS-1:0] presc;
  logic [WIDTH-1:0]         seed;
  logic [WIDTH-1:0]         rule;
  logic [WIDTH-1:0]         next_o;
  logic [LHCA_PERIOD_W-1:0] step_cnt;
  logic                     tick;
  logic                     cmd_fire;
  logic                     do_step;
  logic                     ready_next;
  logic                     running_next;

  assign tick     = &presc;
  assign cmd_fire = CMD_VALID & CMD_READY;
  // An accepted command in RUN swallows a coincident tick.
  assign do_step  = (state == STEP) | ((state == RUN) & tick & ~cmd_fire);

  lhca_next #(.WIDTH(WIDTH)) u_next (
    .s    (O),
    .rule (rule),
    .n    (next_o)
  );

  always_ff @(posedge CLK) begin
    if (RESET) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (cmd_fire && CMD_OP == LHCA_OP_RUN) state_next = RUN;
        else if (cmd_fire && CMD_OP == LHCA_OP_STOPSTEP && CMD_DATA[0]) state_next = STEP;
      end
      RUN: begin
        if (cmd_fire && CMD_OP == LHCA_OP_STOPSTEP) state_next = CMD_DATA[0] ? STEP : IDLE;
      end
      STEP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ready_next   = 1'b1;
    running_next = 1'b0;
    if (state_next == STEP) ready_next = 1'b0;
    if (state_next == RUN)  running_next = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      CMD_READY <= 1'b1;
      RUNNING   <= 1'b0;
    end else begin
      CMD_READY <= ready_next;
      RUNNING   <= running_next;
    end
  end

  // CA state, configuration and period measurement.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc        <= '0;
      O            <= SEED_RESET;
      seed         <= SEED_RESET;
      rule         <= RULE_RESET;
      step_cnt     <= '0;
      STEP_PULSE   <= 1'b0;
      PERIOD       <= '0;
      PERIOD_VALID <= 1'b0;
    end else begin
      presc      <= presc + PRESCALE_BITS'(1);
      STEP_PULSE <= do_step;
      if (cmd_fire && CMD_OP == LHCA_OP_LOAD) begin
        seed         <= CMD_DATA;
        O            <= CMD_DATA;
        step_cnt     <= '0;
        PERIOD_VALID <= 1'b0;
      end else if (cmd_fire && CMD_OP == LHCA_OP_RULE) begin
        rule         <= CMD_DATA;
        O            <= seed;
        step_cnt     <= '0;
        PERIOD_VALID <= 1'b0;
      end else if (do_step) begin
        O <= next_o;
        if (next_o == seed && step_cnt != CNT_SAT) begin
          PERIOD       <= step_cnt + LHCA_PERIOD_W'(1);
          PERIOD_VALID <= 1'b1;
          step_cnt     <= '0;
        end else if (step_cnt != CNT_SAT) begin
          step_cnt <= step_cnt + LHCA_PERIOD_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_lhca_sequencer.sv
// Directed self-checking bench for lhca_sequencer (prescaler shortened to 3 bits).
module tb_lhca_sequencer;
  import lhca_pkg::*;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_data;
  logic [7:0]  o;
  logic        step_pulse;
  logic        running;
  logic [15:0] period;
  logic        period_valid;

  logic [7:0]  m_s;
  logic [7:0]  m_rule;
  logic [7:0]  m_n;

  int pass_cnt  = 0;
  int total_cnt = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  lhca_sequencer #(
    .WIDTH         (8),
    .PRESCALE_BITS (3),
    .RULE_RESET    (8'h06),
    .SEED_RESET    (8'h01)
  ) dut (
    .CLK          (clk),
    .RESET        (reset),
    .CMD_VALID    (cmd_valid),
    .CMD_READY    (cmd_ready),
    .CMD_OP       (cmd_op),
    .CMD_DATA     (cmd_data),
    .O            (o),
    .STEP_PULSE   (step_pulse),
    .RUNNING      (running),
    .PERIOD       (period),
    .PERIOD_VALID (period_valid)
  );

  lhca_next #(.WIDTH(8)) ref_next (
    .s    (m_s),
    .rule (m_rule),
    .n    (m_n)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Called at a negedge; the command is accepted on the following posedge.
  task automatic send(input logic [1:0] op, input logic [7:0] data);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_data  = 8'd0;
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_o"},            32'(o),            32'h01);
    check({pfx, "_step_pulse"},   32'(step_pulse),   32'h0);
    check({pfx, "_running"},      32'(running),      32'h0);
    check({pfx, "_period"},       32'(period),       32'h0);
    check({pfx, "_period_valid"}, 32'(period_valid), 32'h0);
    check({pfx, "_ready"},        32'(cmd_ready),    32'h1);
  endtask

  logic [7:0] run_seq [5];
  logic [7:0] rs, rr, cur;
  int         npulse, last_k, mp, steps;
  bit         found, ok, done;

  initial begin
    // 01 -> 02 -> 07 -> 0B -> 11 -> 2A under rule 06
    run_seq[0] = 8'h02; run_seq[1] = 8'h07; run_seq[2] = 8'h0B;
    run_seq[3] = 8'h11; run_seq[4] = 8'h2A;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'd0;
    m_s = 8'd0; m_rule = 8'd0; mp = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_reset("rst");

    // Single steps with defaults
    send(LHCA_OP_STOPSTEP, 8'h01);
    check("step1_ready_low", 32'(cmd_ready), 32'h0);
    check("step1_o_hold",    32'(o),         32'h01);
    @(negedge clk);
    check("step1_o",     32'(o),          32'h02);
    check("step1_pulse", 32'(step_pulse), 32'h1);
    check("step1_ready", 32'(cmd_ready),  32'h1);
    @(negedge clk);
    check("step1_pulse_end", 32'(step_pulse), 32'h0);
    send(LHCA_OP_STOPSTEP, 8'h01);
    @(negedge clk);
    check("step2_o",     32'(o),            32'h07);
    check("step2_pulse", 32'(step_pulse),   32'h1);
    check("step2_pv",    32'(period_valid), 32'h0);

    // Zero seed is a fixed point
    send(LHCA_OP_LOAD, 8'h00);
    check("zero_o",  32'(o),            32'h00);
    check("zero_pv", 32'(period_valid), 32'h0);
    send(LHCA_OP_STOPSTEP, 8'h01);
    @(negedge clk);
    check("zero_step_o",  32'(o),            32'h00);
    check("zero_period",  32'(period),       32'h1);
    check("zero_pv_set",  32'(period_valid), 32'h1);

    // RUN for 40 cycles: 5 steps, 8 cycles apart
    send(LHCA_OP_LOAD, 8'h01);
    check("run_load_o",  32'(o),            32'h01);
    check("run_load_pv", 32'(period_valid), 32'h0);
    send(LHCA_OP_RUN, 8'h00);
    check("run_running", 32'(running), 32'h1);
    npulse = 0; last_k = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (step_pulse) begin
        if (npulse < 5) check("run_o_seq", 32'(o), 32'(run_seq[npulse]));
        if (npulse > 0) check("run_spacing", 32'(k - last_k), 32'd8);
        last_k = k;
        npulse++;
      end
    end
    check("run_step_count", 32'(npulse), 32'd5);
    send(LHCA_OP_STOPSTEP, 8'h00);
    check("stop_running", 32'(running),    32'h0);
    check("stop_pulse",   32'(step_pulse), 32'h0);
    npulse = 0;
    repeat (20) begin
      @(negedge clk);
      if (step_pulse) npulse++;
    end
    check("stop_no_steps", 32'(npulse), 32'd0);
    check("stop_o_frozen", 32'(o),      32'h2A);

    // LOAD_SEED accepted exactly on a TICK in RUN
    send(LHCA_OP_RUN, 8'h00);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (step_pulse) found = 1'b1;
    end
    check("tick_found", 32'(found), 32'h1);
    repeat (7) @(negedge clk);
    send(LHCA_OP_LOAD, 8'h5A);
    check("tick_load_o",       32'(o),            32'h5A);
    check("tick_step_dropped", 32'(step_pulse),   32'h0);
    check("tick_running",      32'(running),      32'h1);
    check("tick_pv",           32'(period_valid), 32'h0);
    send(LHCA_OP_STOPSTEP, 8'h00);

    // Random seed/rule; reference period from lhca_next
    ok = 1'b0; rs = 8'h01; rr = 8'h06;
    for (int a = 0; a < 64 && !ok; a++) begin
      rr = 8'($urandom);
      rs = 8'($urandom);
      cur = rs;
      m_rule = rr;
      for (int k = 1; k <= 256; k++) begin
        m_s = cur;
        #1;
        cur = m_n;
        if (cur == rs) begin
          mp = k;
          ok = 1'b1;
          break;
        end
      end
    end
    check("rand_model_found", 32'(ok), 32'h1);
    @(negedge clk);
    send(LHCA_OP_RULE, rr);
    send(LHCA_OP_LOAD, rs);
    check("rand_load_o", 32'(o), 32'(rs));
    steps = 0; done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      send(LHCA_OP_STOPSTEP, 8'h01);
      @(negedge clk);
      steps++;
      if (period_valid) done = 1'b1;
    end
    check("rand_done",   32'(done),   32'h1);
    check("rand_o_seed", 32'(o),      32'(rs));
    check("rand_period", 32'(period), 32'(mp));
    check("rand_steps",  32'(steps),  32'(mp));

    // RESET mid-run beats a same-cycle command
    send(LHCA_OP_RUN, 8'h00);
    repeat (11) @(negedge clk);
    reset = 1'b1;
    cmd_valid = 1'b1; cmd_op = LHCA_OP_LOAD; cmd_data = 8'h33;
    @(negedge clk);
    reset = 1'b0;
    cmd_valid = 1'b0; cmd_op = 2'd0; cmd_data = 8'd0;
    check_reset("midrst");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
